// File: rtl/ascon_io_frontend.sv
// ascon_io_frontend
//   Pin-level front end for the ASCON datapath. Deserializes nibble-wide
//   framed input from GPIO into tagged 64-bit beats for the core, and
//   serializes 64-bit core results back out as 32 dibits.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   pin_in[5:0]  [3:0] nibble, [4] strobe, [5] frame
//   pin_out[2:0] [1:0] result dibit, [2] result strobe
//   out_valid/out_ready         beat handshake toward the core
//   out_data/out_type/out_last/out_decrypt  beat payload and tags
//   res_valid/res_ready/res_data            result word from the core
//   err          sticky protocol error for the current frame
module ascon_io_frontend #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  pin_in,
  output logic [2:0]  pin_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [1:0]  out_type,
  output logic        out_last,
  output logic        out_decrypt,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [63:0] res_data,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, ERR} state_t;
  state_t state;

  // Input synchronizer
  logic [5:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [5:0] pin_s;
  logic       frame_d;
  logic       frame_rise;
  logic       frame_fall;
  logic       stb;
  logic [3:0] nib;

  assign pin_s      = sync_q[SYNC_STAGES-1];
  assign nib        = pin_s[3:0];
  assign stb        = pin_s[4];
  assign frame_rise = pin_s[5] & ~frame_d;
  assign frame_fall = ~pin_s[5] & frame_d;

  // Frame header, nibble counter, shift register and completed-beat tags
  logic [1:0]  hdr_type;
  logic        hdr_last;
  logic        hdr_dec;
  logic [5:0]  cnt;
  logic [5:0]  cnt_nx;
  logic [5:0]  exp_len;
  logic [63:0] sr;
  logic        full;
  logic [1:0]  full_type;
  logic        full_last;
  logic        full_dec;
  logic        move;
  logic        pending;

  assign cnt_nx  = cnt + 6'd1;
  assign exp_len = hdr_type[1] ? 6'd16 : 6'd32;
  // A completed beat leaves the shift register when the holding register
  // is free or is being drained on this same edge.
  assign move    = full & (~out_valid | out_ready);
  assign pending = full & ~move;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      frame_d     <= 1'b0;
      err         <= 1'b0;
      hdr_type    <= '0;
      hdr_last    <= 1'b0;
      hdr_dec     <= 1'b0;
      cnt         <= '0;
      sr          <= '0;
      full        <= 1'b0;
      full_type   <= '0;
      full_last   <= 1'b0;
      full_dec    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_type    <= '0;
      out_last    <= 1'b0;
      out_decrypt <= 1'b0;
    end else begin
      frame_d <= pin_s[5];

      if (move) begin
        out_valid   <= 1'b1;
        out_data    <= sr;
        out_type    <= full_type;
        out_last    <= full_last;
        out_decrypt <= full_dec;
        full        <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (frame_rise) begin
            state <= HDR;
            err   <= 1'b0;
          end
        end
        HDR: begin
          if (frame_fall) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (stb) begin
            hdr_type <= nib[1:0];
            hdr_last <= nib[2];
            hdr_dec  <= nib[3];
            cnt      <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (frame_fall) begin
            if (cnt == exp_len) begin
              state <= IDLE;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end else if (stb) begin
            if (cnt == exp_len || pending) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              // Shifting while a beat moves out is safe: the move reads
              // the pre-edge contents, and 16 new nibbles overwrite the rest.
              sr  <= {sr[59:0], nib};
              cnt <= cnt_nx;
              if (cnt_nx[3:0] == 4'd0) begin
                full      <= 1'b1;
                full_type <= hdr_type;
                full_dec  <= hdr_dec;
                full_last <= hdr_type[1] ? hdr_last : (cnt_nx == 6'd32);
              end
            end
          end
        end
        ERR: begin
          if (!pin_s[5]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result serializer
  logic [63:0] ser_sr;
  logic [4:0]  ser_cnt;
  logic        busy;

  assign res_ready = rst & ~busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_sr  <= '0;
      ser_cnt <= '0;
      busy    <= 1'b0;
      pin_out <= '0;
    end else if (busy) begin
      pin_out <= {1'b1, ser_sr[63:62]};
      ser_sr  <= {ser_sr[61:0], 2'b00};
      ser_cnt <= ser_cnt + 5'd1;
      if (ser_cnt == 5'd31) busy <= 1'b0;
    end else begin
      pin_out <= '0;
      if (res_valid) begin
        ser_sr  <= res_data;
        ser_cnt <= '0;
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ascon_io_frontend.sv
// tb_ascon_io_frontend
//   Directed self-checking bench for ascon_io_frontend: input framing,
//   beat delivery/backpressure, protocol errors, result serializer, reset.
module tb_ascon_io_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pin_in;
  logic [2:0]  pin_out;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  out_type;
  logic        out_last;
  logic        out_decrypt;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        err;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  logic [3:0]  nib_buf [64];
  logic [67:0] beats [$];
  int unsigned vcnt = 0;

  localparam logic [67:0] AD_BEAT  = {1'b0, 1'b1, 2'b10, 64'h0123456789ABCDEF};
  localparam logic [67:0] KEY_B1   = {1'b0, 1'b0, 2'b00, 64'h0001020304050607};
  localparam logic [67:0] KEY_B2   = {1'b0, 1'b1, 2'b00, 64'h08090A0B0C0D0E0F};
  localparam logic [67:0] NONCE_B1 = {1'b1, 1'b0, 2'b01, 64'h0001020304050607};

  ascon_io_frontend #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pin_in      (pin_in),
    .pin_out     (pin_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_type    (out_type),
    .out_last    (out_last),
    .out_decrypt (out_decrypt),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Beats accepted by the core are recorded at the falling edge.
  always @(negedge clk) begin
    if (rst && out_valid) vcnt++;
    if (rst && out_valid && out_ready)
      beats.push_back({out_decrypt, out_last, out_type, out_data});
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic s, input logic [3:0] n);
    pin_in = {f, s, n};
    tick();
  endtask

  task automatic frame_open(input logic [3:0] hdr);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b1, 1'b1, hdr);
  endtask

  task automatic send_nibs(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b1, 1'b1, nib_buf[i]);
  endtask

  task automatic frame_close();
    drive(1'b0, 1'b0, 4'h0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic load_ad();
    for (int unsigned i = 0; i < 16; i++) nib_buf[i] = 4'(i);
  endtask

  task automatic load_key();
    for (int unsigned i = 0; i < 32; i++) nib_buf[i] = (i % 2 == 0) ? 4'h0 : 4'(i / 2);
  endtask

  task automatic release_reset();
    pin_in    = '0;
    res_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // One result word; also checks the serializer idles at 000 on the
  // handshake cycle itself.
  task automatic ser_word(input logic [63:0] w);
    logic [63:0] tmp;
    res_data  = w;
    res_valid = 1'b1;
    chk("ser_ready_before", 128'(res_ready), 128'(1'b1));
    tick();
    res_valid = 1'b0;
    chk("ser_ready_busy0", 128'(res_ready), 128'(1'b0));
    chk("ser_pin_idle0", 128'(pin_out), 128'(3'b000));
    for (int unsigned k = 1; k <= 32; k++) begin
      tick();
      tmp = w << (2 * (k - 1));
      chk($sformatf("ser_dibit%0d", k), 128'(pin_out), 128'({1'b1, tmp[63:62]}));
      chk($sformatf("ser_ready%0d", k), 128'(res_ready), 128'(k == 32));
    end
  endtask

  int unsigned base;
  int unsigned v0;

  initial begin
    rst       = 1'b0;
    pin_in    = '0;
    out_ready = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    #3;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data", 128'(out_data), 128'(64'h0));
    chk("rst_err", 128'(err), 128'(1'b0));
    chk("rst_pin_out", 128'(pin_out), 128'(3'b000));
    chk("rst_res_ready_low", 128'(res_ready), 128'(1'b0));
    release_reset();
    chk("rst_res_ready_high", 128'(res_ready), 128'(1'b1));

    // AD frame with latency check
    out_ready = 1'b1;
    load_ad();
    base = beats.size();
    frame_open(4'h6);
    send_nibs(16);
    frame_close();
    chk("ad_lat_n1", 128'(out_valid), 128'(1'b0));
    tick();
    chk("ad_lat_n2", 128'(out_valid), 128'(1'b0));
    tick();
    chk("ad_lat_n3", 128'(out_valid), 128'(1'b1));
    chk("ad_beat", 128'({out_decrypt, out_last, out_type, out_data}), 128'(AD_BEAT));
    chk("ad_err", 128'(err), 128'(1'b0));
    tick();
    chk("ad_valid_drop", 128'(out_valid), 128'(1'b0));
    chk("ad_count", 128'(beats.size() - base), 128'(1));

    // Key frame with backpressure: beat 2 waits pending
    out_ready = 1'b0;
    load_key();
    base = beats.size();
    frame_open(4'h0);
    send_nibs(32);
    frame_close();
    idle(4);
    chk("key_b1_held", 128'({out_decrypt, out_last, out_type, out_data}), 128'(KEY_B1));
    chk("key_b1_valid", 128'(out_valid), 128'(1'b1));
    chk("key_err", 128'(err), 128'(1'b0));
    out_ready = 1'b1;
    idle(4);
    out_ready = 1'b0;
    chk("key_count", 128'(beats.size() - base), 128'(2));
    if (beats.size() - base >= 2) begin
      chk("key_b1", 128'(beats[base]), 128'(KEY_B1));
      chk("key_b2", 128'(beats[base+1]), 128'(KEY_B2));
    end

    // Overflow: nonce, decrypt, extra strobe while beat 2 is pending
    base = beats.size();
    frame_open(4'h9);
    send_nibs(32);
    drive(1'b1, 1'b1, 4'h5);
    idle(3);
    chk("ovf_err", 128'(err), 128'(1'b1));
    chk("ovf_valid", 128'(out_valid), 128'(1'b1));
    chk("ovf_b1_only", 128'({out_decrypt, out_last, out_type, out_data}), 128'(NONCE_B1));
    drive(1'b1, 1'b1, 4'h7);
    frame_close();
    idle(4);
    chk("ovf_err_sticky", 128'(err), 128'(1'b1));
    chk("ovf_none_taken", 128'(beats.size() - base), 128'(0));
    out_ready = 1'b1;
    idle(4);
    out_ready = 1'b0;
    if (beats.size() > base) chk("ovf_first_beat", 128'(beats[base]), 128'(NONCE_B1));
    else chk("ovf_first_beat", 128'(0), 128'(NONCE_B1));

    // Reset in the middle of a serialization (dibit 5); err still set
    res_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    idle(5);
    chk("mser_dibit5", 128'(pin_out), 128'(3'b111));
    rst = 1'b0;
    #1;
    chk("mser_pin_out", 128'(pin_out), 128'(3'b000));
    chk("mser_res_ready", 128'(res_ready), 128'(1'b0));
    chk("mser_err", 128'(err), 128'(1'b0));
    chk("mser_out_data", 128'(out_data), 128'(64'h0));
    chk("mser_out_type", 128'({out_decrypt, out_last, out_type}), 128'(4'h0));
    release_reset();
    chk("mser_ready_after", 128'(res_ready), 128'(1'b1));
    chk("mser_pin_after", 128'(pin_out), 128'(3'b000));

    // Short PT frame: 10 nibbles
    out_ready = 1'b1;
    load_ad();
    v0 = vcnt;
    frame_open(4'hF);
    send_nibs(10);
    frame_close();
    idle(4);
    chk("short_err", 128'(err), 128'(1'b1));
    chk("short_no_valid", 128'(vcnt - v0), 128'(0));

    // Next frame clears err and delivers normally
    base = beats.size();
    frame_open(4'h6);
    send_nibs(16);
    chk("clr_err", 128'(err), 128'(1'b0));
    frame_close();
    idle(4);
    chk("clr_count", 128'(beats.size() - base), 128'(1));
    if (beats.size() > base) chk("clr_beat", 128'(beats[base]), 128'(AD_BEAT));

    // Serializer: spec word, then a back-to-back word
    ser_word(64'hC000000000000003);
    ser_word(64'h123456789ABCDEF0);
    tick();
    chk("ser_end_idle", 128'(pin_out), 128'(3'b000));
    chk("ser_end_ready", 128'(res_ready), 128'(1'b1));

    // Reset mid-frame (after nibble 8), then a clean AD frame
    frame_open(4'h6);
    send_nibs(8);
    pin_in = '0;
    rst = 1'b0;
    #1;
    chk("mfr_out_valid", 128'(out_valid), 128'(1'b0));
    chk("mfr_out_data", 128'(out_data), 128'(64'h0));
    chk("mfr_err", 128'(err), 128'(1'b0));
    chk("mfr_pin_out", 128'(pin_out), 128'(3'b000));
    release_reset();
    base = beats.size();
    frame_open(4'h6);
    send_nibs(16);
    frame_close();
    idle(4);
    chk("post_rst_count", 128'(beats.size() - base), 128'(1));
    if (beats.size() > base) chk("post_rst_beat", 128'(beats[base]), 128'(AD_BEAT));
    chk("post_rst_err", 128'(err), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
